// File: rtl/pe_array_pkg.sv
// Message layout shared by the weight-stationary PE array and its PEs.
// Row messages are {is_flush, is_weight, data}; column results are {is_flush, data}.
package pe_array_pkg;

  localparam int MSG_FLAG_BITS = 2;
  localparam int PP_FLAG_BITS  = 1;

  typedef enum logic [1:0] {
    KIND_ACT    = 2'd0,
    KIND_WEIGHT = 2'd1,
    KIND_FLUSH  = 2'd2
  } msgKind_t;

  function automatic int msgWidth(input int bitWidth);
    return bitWidth + MSG_FLAG_BITS;
  endfunction

  function automatic int ppMsgWidth(input int bitWidth);
    return bitWidth + PP_FLAG_BITS;
  endfunction

  function automatic int isFlushPos(input int bitWidth);
    return msgWidth(bitWidth) - 1;
  endfunction

  function automatic int isWeightPos(input int bitWidth);
    return msgWidth(bitWidth) - 2;
  endfunction

  // A flush wins over the weight flag, so a flush never reloads a weight.
  function automatic msgKind_t decodeKind(input logic isFlush, input logic isWeight);
    if (isFlush) begin
      return KIND_FLUSH;
    end
    if (isWeight) begin
      return KIND_WEIGHT;
    end
    return KIND_ACT;
  endfunction

endpackage

// File: rtl/processing_element.sv
// One weight-stationary PE: weight register, MAC, and one registered
// output stage toward the right (activations/weights) and one downward (psums).
module processing_element
  import pe_array_pkg::*;
#(
  parameter int BIT_WIDTH = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [msgWidth(BIT_WIDTH)-1:0]    i_left_msg,
  input  logic                              i_left_val,
  output logic                              o_left_rdy,
  input  logic [ppMsgWidth(BIT_WIDTH)-1:0]  i_up_msg,
  input  logic                              i_up_val,
  output logic                              o_up_rdy,
  output logic [msgWidth(BIT_WIDTH)-1:0]    o_right_msg,
  output logic                              o_right_val,
  input  logic                              i_right_rdy,
  output logic [ppMsgWidth(BIT_WIDTH)-1:0]  o_down_msg,
  output logic                              o_down_val,
  input  logic                              i_down_rdy
);

  localparam int MSG_WIDTH    = msgWidth(BIT_WIDTH);
  localparam int PP_MSG_WIDTH = ppMsgWidth(BIT_WIDTH);
  localparam int IS_FLUSH     = isFlushPos(BIT_WIDTH);
  localparam int IS_WEIGHT    = isWeightPos(BIT_WIDTH);

  msgKind_t                 w_kind;
  logic [BIT_WIDTH-1:0]     w_data;
  logic                     w_rightCanAccept;
  logic                     w_downCanAccept;
  logic                     w_fireWeight;
  logic                     w_fireCompute;
  logic [2*BIT_WIDTH-1:0]   w_prod;
  logic [BIT_WIDTH-1:0]     w_sum;
  logic                     w_unused;

  logic [BIT_WIDTH-1:0]     r_weight;
  logic [MSG_WIDTH-1:0]     r_rightMsg;
  logic                     r_rightVal;
  logic [PP_MSG_WIDTH-1:0]  r_downMsg;
  logic                     r_downVal;

  assign w_kind = decodeKind(i_left_msg[IS_FLUSH], i_left_msg[IS_WEIGHT]);
  assign w_data = i_left_msg[BIT_WIDTH-1:0];

  assign w_rightCanAccept = ~r_rightVal | i_right_rdy;
  assign w_downCanAccept  = ~r_downVal | i_down_rdy;

  // Weights only need room to the right; activations and flushes also
  // consume the psum from above and need room in both stages.
  assign o_left_rdy = (w_kind == KIND_WEIGHT) ? w_rightCanAccept
                    : (w_rightCanAccept & w_downCanAccept & i_up_val);
  assign o_up_rdy   = i_left_val & (w_kind != KIND_WEIGHT)
                    & w_rightCanAccept & w_downCanAccept;

  assign w_fireWeight  = i_left_val & (w_kind == KIND_WEIGHT) & w_rightCanAccept;
  assign w_fireCompute = i_left_val & i_up_val & (w_kind != KIND_WEIGHT)
                       & w_rightCanAccept & w_downCanAccept;

  assign w_prod = {{BIT_WIDTH{1'b0}}, w_data} * {{BIT_WIDTH{1'b0}}, r_weight};
  assign w_sum  = i_up_msg[BIT_WIDTH-1:0] + w_prod[BIT_WIDTH-1:0];

  assign w_unused = ^{i_up_msg[PP_MSG_WIDTH-1], w_prod[2*BIT_WIDTH-1:BIT_WIDTH]};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_weight   <= '0;
      r_rightMsg <= '0;
      r_rightVal <= 1'b0;
    end else if (w_fireWeight) begin
      r_weight   <= w_data;
      r_rightMsg <= {2'b01, r_weight};
      r_rightVal <= 1'b1;
    end else if (w_fireCompute) begin
      r_rightMsg <= i_left_msg;
      r_rightVal <= 1'b1;
    end else if (i_right_rdy) begin
      r_rightVal <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_downMsg <= '0;
      r_downVal <= 1'b0;
    end else if (w_fireCompute) begin
      r_downMsg <= (w_kind == KIND_FLUSH) ? {1'b1, {BIT_WIDTH{1'b0}}}
                                          : {1'b0, w_sum};
      r_downVal <= 1'b1;
    end else if (i_down_rdy) begin
      r_downVal <= 1'b0;
    end
  end

  assign o_right_msg = r_rightMsg;
  assign o_right_val = r_rightVal;
  assign o_down_msg  = r_downMsg;
  assign o_down_val  = r_downVal;

endmodule

// File: rtl/processing_element_array.sv
// NUM_ROWS x NUM_COLS weight-stationary systolic grid: rows feed activations
// and weights from the left, bottom-row partial sums become column results.
module processing_element_array
  import pe_array_pkg::*;
#(
  parameter int NUM_ROWS  = 2,
  parameter int NUM_COLS  = 2,
  parameter int BIT_WIDTH = 8
) (
  input  logic                                           i_clk,
  input  logic                                           i_rst,
  input  logic [NUM_ROWS-1:0][msgWidth(BIT_WIDTH)-1:0]   i_msg_recv_msg,
  input  logic [NUM_ROWS-1:0]                            i_msg_recv_val,
  output logic [NUM_ROWS-1:0]                            o_msg_recv_rdy,
  output logic [NUM_COLS-1:0][ppMsgWidth(BIT_WIDTH)-1:0] o_prod_send_msg,
  output logic [NUM_COLS-1:0]                            o_prod_send_val,
  input  logic [NUM_COLS-1:0]                            i_prod_send_rdy
);

  localparam int MSG_WIDTH    = msgWidth(BIT_WIDTH);
  localparam int PP_MSG_WIDTH = ppMsgWidth(BIT_WIDTH);

  // Each PE owns its link wires; neighbours are reached by generate-scope
  // name so the ready chains never alias into one shared array variable.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      logic [MSG_WIDTH-1:0]    w_leftMsg;
      logic                    w_leftVal;
      logic                    w_leftRdy;
      logic [PP_MSG_WIDTH-1:0] w_upMsg;
      logic                    w_upVal;
      logic                    w_upRdy;
      logic [MSG_WIDTH-1:0]    w_rightMsg;
      logic                    w_rightVal;
      logic                    w_rightRdy;
      logic [PP_MSG_WIDTH-1:0] w_downMsg;
      logic                    w_downVal;
      logic                    w_downRdy;

      if (c == 0) begin : g_leftEdge
        assign w_leftMsg = i_msg_recv_msg[r];
        assign w_leftVal = i_msg_recv_val[r];
        assign o_msg_recv_rdy[r] = w_leftRdy & i_rst;
      end else begin : g_leftLink
        assign w_leftMsg = g_col[c-1].w_rightMsg;
        assign w_leftVal = g_col[c-1].w_rightVal;
      end

      if (c == NUM_COLS - 1) begin : g_rightEdge
        logic w_unusedRight;
        assign w_rightRdy    = 1'b1;
        assign w_unusedRight = ^{w_rightMsg, w_rightVal};
      end else begin : g_rightLink
        assign w_rightRdy = g_col[c+1].w_leftRdy;
      end

      if (r == 0) begin : g_topEdge
        logic w_unusedUp;
        assign w_upMsg    = '0;
        assign w_upVal    = 1'b1;
        assign w_unusedUp = w_upRdy;
      end else begin : g_upLink
        assign w_upMsg = g_row[r-1].g_col[c].w_downMsg;
        assign w_upVal = g_row[r-1].g_col[c].w_downVal;
      end

      if (r == NUM_ROWS - 1) begin : g_bottomEdge
        assign w_downRdy = i_prod_send_rdy[c];
      end else begin : g_downLink
        assign w_downRdy = g_row[r+1].g_col[c].w_upRdy;
      end

      processing_element #(
        .BIT_WIDTH (BIT_WIDTH)
      ) u_pe (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_left_msg  (w_leftMsg),
        .i_left_val  (w_leftVal),
        .o_left_rdy  (w_leftRdy),
        .i_up_msg    (w_upMsg),
        .i_up_val    (w_upVal),
        .o_up_rdy    (w_upRdy),
        .o_right_msg (w_rightMsg),
        .o_right_val (w_rightVal),
        .i_right_rdy (w_rightRdy),
        .o_down_msg  (w_downMsg),
        .o_down_val  (w_downVal),
        .i_down_rdy  (w_downRdy)
      );
    end
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_out
    assign o_prod_send_msg[c] = g_row[NUM_ROWS-1].g_col[c].w_downMsg;
    assign o_prod_send_val[c] = g_row[NUM_ROWS-1].g_col[c].w_downVal;
  end

endmodule

// File: tb/tb_processing_element_array.sv
// Self-checking bench for the 2x2 PE array: directed steps feed a per-row
// send queue and a per-column scoreboard filled from a small weight model.
module tb_processing_element_array;

  localparam int NR = 2;
  localparam int NC = 2;
  localparam int BW = 8;
  localparam int MW = BW + 2;
  localparam int PW = BW + 1;

  localparam logic [MW-1:0] IDLE_MSG = {2'b01, 8'h00};

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NR-1:0][MW-1:0]  msgIn;
  logic [NR-1:0]          valIn;
  logic [NR-1:0]          rdyOut;
  logic [NC-1:0][PW-1:0]  prodMsg;
  logic [NC-1:0]          prodVal;
  logic [NC-1:0]          prodRdy;

  logic [MW-1:0] txQ0 [$];
  logic [MW-1:0] txQ1 [$];
  logic [PW-1:0] expQ0 [$];
  logic [PW-1:0] expQ1 [$];

  int mW [2][2];
  int nAsserts = 0;
  int nFails   = 0;
  logic sawDrop;

  always #5 clk = ~clk;

  processing_element_array #(
    .NUM_ROWS  (NR),
    .NUM_COLS  (NC),
    .BIT_WIDTH (BW)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_msg_recv_msg  (msgIn),
    .i_msg_recv_val  (valIn),
    .o_msg_recv_rdy  (rdyOut),
    .o_prod_send_msg (prodMsg),
    .o_prod_send_val (prodVal),
    .i_prod_send_rdy (prodRdy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [MW-1:0] m0, input logic [MW-1:0] m1);
    txQ0.push_back(m0);
    txQ1.push_back(m1);
  endtask

  // Row r receives W[r][1] first, then W[r][0], so PE(r,c) ends up with W[r][c].
  task automatic loadWeights(input logic [7:0] w00, input logic [7:0] w01,
                             input logic [7:0] w10, input logic [7:0] w11);
    applyStimulus({2'b01, w01}, {2'b01, w11});
    applyStimulus({2'b01, w00}, {2'b01, w10});
    mW[0][0] = int'(w00);
    mW[0][1] = int'(w01);
    mW[1][0] = int'(w10);
    mW[1][1] = int'(w11);
  endtask

  task automatic sendVector(input logic [7:0] a0, input logic [7:0] a1);
    int s0;
    int s1;
    logic [7:0] t0;
    logic [7:0] t1;
    applyStimulus({2'b00, a0}, {2'b00, a1});
    s0 = int'(a0) * mW[0][0] + int'(a1) * mW[1][0];
    s1 = int'(a0) * mW[0][1] + int'(a1) * mW[1][1];
    t0 = s0[7:0];
    t1 = s1[7:0];
    expQ0.push_back({1'b0, t0});
    expQ1.push_back({1'b0, t1});
  endtask

  task automatic sendFlush();
    applyStimulus({2'b10, 8'h00}, {2'b10, 8'h00});
    expQ0.push_back(9'h100);
    expQ1.push_back(9'h100);
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int pending;
    pending = txQ0.size() + txQ1.size() + expQ0.size() + expQ1.size();
    for (int i = 0; i < budget && pending != 0; i++) begin
      @(negedge clk);
      #6;
      pending = txQ0.size() + txQ1.size() + expQ0.size() + expQ1.size();
    end
    checkOutput(tag, pending, 0);
  endtask

  task automatic monitorCol(input int c);
    logic have;
    logic [PW-1:0] e;
    logic [PW-1:0] obs;
    e   = '0;
    obs = prodMsg[c];
    if (c == 0) begin
      have = expQ0.size() > 0;
      if (have) e = expQ0.pop_front();
    end else begin
      have = expQ1.size() > 0;
      if (have) e = expQ1.pop_front();
    end
    checkOutput($sformatf("col%0d resultExpected", c), {31'b0, have}, 32'd1);
    if (have) checkOutput($sformatf("col%0d result", c), obs, e);
  endtask

  // Row driver: present the head of each row queue, retire it once accepted.
  initial begin
    valIn = '0;
    msgIn = {IDLE_MSG, IDLE_MSG};
    forever begin
      @(negedge clk);
      if (txQ0.size() > 0) begin
        valIn[0] = 1'b1;
        msgIn[0] = txQ0[0];
      end else begin
        valIn[0] = 1'b0;
        msgIn[0] = IDLE_MSG;
      end
      if (txQ1.size() > 0) begin
        valIn[1] = 1'b1;
        msgIn[1] = txQ1[0];
      end else begin
        valIn[1] = 1'b0;
        msgIn[1] = IDLE_MSG;
      end
      #4;
      if (rst && valIn[0] && rdyOut[0] && txQ0.size() > 0) void'(txQ0.pop_front());
      if (rst && valIn[1] && rdyOut[1] && txQ1.size() > 0) void'(txQ1.pop_front());
    end
  end

  // Column monitor: compare every accepted result against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        for (int c = 0; c < NC; c++) begin
          if (prodVal[c] && prodRdy[c]) monitorCol(c);
        end
      end
    end
  end

  initial begin
    rst     = 1'b0;
    prodRdy = 2'b11;
    sawDrop = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) mW[r][c] = 0;
    end

    repeat (3) @(negedge clk);
    #2;
    checkOutput("resetVal", prodVal, 0);
    checkOutput("resetMsg", prodMsg, 0);
    checkOutput("resetRdy", rdyOut, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rdyAfterRelease", rdyOut, 2'b11);

    $display("[TB] identity weights");
    loadWeights(8'd1, 8'd0, 8'd0, 8'd1);
    sendVector(8'd3, 8'd4);
    sendVector(8'd1, 8'd2);
    sendFlush();
    waitDrain("identityDrain", 200);

    $display("[TB] general product");
    loadWeights(8'd1, 8'd2, 8'd3, 8'd4);
    sendVector(8'd5, 8'd6);
    waitDrain("generalDrain", 200);

    $display("[TB] overflow");
    loadWeights(8'd16, 8'd16, 8'd16, 8'd16);
    sendVector(8'd16, 8'd16);
    waitDrain("overflowDrain", 200);

    $display("[TB] backpressure on column 1");
    loadWeights(8'd1, 8'd2, 8'd3, 8'd4);
    sendVector(8'd1, 8'd2);
    sendVector(8'd3, 8'd4);
    sendVector(8'd5, 8'd6);
    sendVector(8'd7, 8'd8);
    prodRdy[1] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      #3;
      if (rdyOut != 2'b11) sawDrop = 1'b1;
    end
    prodRdy[1] = 1'b1;
    checkOutput("bpRdyDropped", {31'b0, sawDrop}, 32'd1);
    waitDrain("bpDrain", 300);

    $display("[TB] asynchronous reset mid-stream");
    prodRdy = 2'b00;
    loadWeights(8'd1, 8'd2, 8'd3, 8'd4);
    sendVector(8'd1, 8'd1);
    sendVector(8'd2, 8'd2);
    repeat (12) @(negedge clk);
    #2;
    checkOutput("preResetVal", prodVal, 2'b11);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midResetVal", prodVal, 0);
    checkOutput("midResetMsg", prodMsg, 0);
    checkOutput("midResetRdy", rdyOut, 0);
    txQ0.delete();
    txQ1.delete();
    expQ0.delete();
    expQ1.delete();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) mW[r][c] = 0;
    end
    prodRdy = 2'b11;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rdyAfterMidReset", rdyOut, 2'b11);
    sendVector(8'd7, 8'd9);
    waitDrain("zeroWeightDrain", 200);
    loadWeights(8'd2, 8'd0, 8'd0, 8'd3);
    sendVector(8'd10, 8'd20);
    waitDrain("reloadDrain", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
